// File: rtl/stepper_cmd_scheduler.sv
// Command FIFO and move sequencer for the stepper driver: issues queued targets one at a time, waits for completion, then dwells.
// Optional build macro STEPPER_CMD_SKIP_DUP_EN: drop commands whose position equals the last issued one.
module stepper_cmd_scheduler #(
  parameter int DEPTH        = 4,
  parameter int POS_W        = 21,
  parameter int DWELL_CYCLES = 1000000,
  parameter int START_WAIT   = 8
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_data,
  input  logic        flush,
  output logic        cmd_full,
  output logic [31:0] step_data,
  output logic        step_new,
  input  logic        stepper_busy,
  output logic        done_pulse,
  output logic [31:0] status
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [31:0] START_LAST = 32'((START_WAIT > 1) ? START_WAIT - 1 : 0);
  localparam logic [31:0] DWELL_LAST = 32'((DWELL_CYCLES > 1) ? DWELL_CYCLES - 1 : 0);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || POS_W < 1 || POS_W > 32) begin : g_param_check
    $error("stepper_cmd_scheduler: DEPTH must be a power of 2 >= 2 and POS_W in 1..32");
  end

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    ISSUE      = 4'd1,
    WAIT_START = 4'd2,
    WAIT_DONE  = 4'd3,
    DWELL      = 4'd4
  } state_t;

  state_t          state, next_state;
  logic [31:0]     fifo_mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            overflow;
  logic [31:0]     start_cnt, dwell_cnt;
  logic [31:0]     head;
  logic            wr_en, pop, issue_go, done_go, dup_hit;

  assign cmd_full = (count == CNT_FULL);
  assign head     = fifo_mem[rd_ptr];
  // Writes are judged on the registered full flag, so a same-cycle pop never rescues a write into a full FIFO.
  assign wr_en    = cmd_wr && !cmd_full && !flush;
  assign status   = {16'b0, overflow, 3'b0, state, 8'(count)};

`ifdef STEPPER_CMD_SKIP_DUP_EN
  logic [POS_W-1:0] last_pos;
  logic             have_last;

  assign dup_hit = have_last && (head[POS_W-1:0] == last_pos);

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      last_pos  <= '0;
      have_last <= 1'b0;
    end else if (issue_go) begin
      last_pos  <= head[POS_W-1:0];
      have_last <= 1'b1;
    end
  end
`else
  assign dup_hit = 1'b0;
`endif

  always_ff @(posedge CLK100MHZ) begin
    if (wr_en) fifo_mem[wr_ptr] <= cmd_data;
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (cmd_wr && cmd_full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state      <= IDLE;
      step_data  <= '0;
      step_new   <= 1'b0;
      done_pulse <= 1'b0;
      start_cnt  <= '0;
      dwell_cnt  <= '0;
    end else begin
      state      <= next_state;
      step_new   <= issue_go;
      done_pulse <= done_go;
      if (issue_go) step_data <= head;
      start_cnt  <= (state == WAIT_START) ? start_cnt + 32'd1 : 32'd0;
      dwell_cnt  <= (state == DWELL) ? dwell_cnt + 32'd1 : 32'd0;
    end
  end

  // A flush between IDLE and ISSUE can leave ISSUE with nothing to pop; it then falls back to IDLE.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    issue_go   = 1'b0;
    done_go    = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) next_state = ISSUE;
      end
      ISSUE: begin
        if (count == '0) begin
          next_state = IDLE;
        end else begin
          pop = 1'b1;
          if (dup_hit) begin
            next_state = IDLE;
          end else begin
            issue_go   = 1'b1;
            next_state = WAIT_START;
          end
        end
      end
      WAIT_START: begin
        if (stepper_busy) begin
          next_state = WAIT_DONE;
        end else if (start_cnt == START_LAST) begin
          done_go    = 1'b1;
          next_state = DWELL;
        end
      end
      WAIT_DONE: begin
        if (!stepper_busy) begin
          done_go    = 1'b1;
          next_state = DWELL;
        end
      end
      DWELL: begin
        if (flush || dwell_cnt == DWELL_LAST) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
